// File: rtl/pixel_shade_pkg.sv
// Shared types and helpers for the pixel shading pipeline.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pixel_shade_pkg;

  // Hit distance is carried at a fixed width so the record type needs no parameter;
  // the top zero-extends its T_W-bit input into it (T_W must not exceed this).
  localparam int REC_T_W = 32;

  typedef enum logic [1:0] {
    COL_RED     = 2'd0,
    COL_BLUE    = 2'd1,
    COL_WHITE   = 2'd2,
    COL_MAGENTA = 2'd3
  } color_e;

  // Sideband that travels with every pixel through all stages.
  typedef struct packed {
    logic [10:0]        x;
    logic [9:0]         y;
    logic               hit;
    logic               fog_en;
    logic [REC_T_W-1:0] t;
  } rec_t;

  // Face brightness in eighths; the unused face codes 6/7 get full brightness.
  function automatic logic [3:0] shade_weight(input logic [2:0] dir);
    case (dir)
      3'd0:    shade_weight = 4'd8;
      3'd1:    shade_weight = 4'd7;
      3'd2:    shade_weight = 4'd6;
      3'd3:    shade_weight = 4'd6;
      3'd4:    shade_weight = 4'd5;
      3'd5:    shade_weight = 4'd4;
      default: shade_weight = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/rgb_lerp.sv
// Per-channel fog blend: (c*(2^W - f) + bg*f) >> W, truncating.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller registers the result under its own enable.
module rgb_lerp #(
  parameter int COLOR_W = 4
) (
  input  logic [COLOR_W-1:0] c,
  input  logic [COLOR_W-1:0] bg,
  input  logic [COLOR_W-1:0] f,
  output logic [COLOR_W-1:0] mix
);

  localparam int SUM_W = 2*COLOR_W + 1;

  logic [COLOR_W:0]   w_c;
  logic [SUM_W-1:0]   sum;
  logic               unused_sum;

  // Weight of the surface colour; f never exceeds 2^W-1 so this stays >= 1.
  assign w_c = (COLOR_W+1)'(1 << COLOR_W) - (COLOR_W+1)'(f);
  assign sum = SUM_W'(c) * SUM_W'(w_c) + SUM_W'(bg) * SUM_W'(f);

  // The blend never exceeds (2^W-1)*2^W, so the top bit is always zero.
  assign mix        = sum[2*COLOR_W-1:COLOR_W];
  assign unused_sum = ^sum;

endmodule

// File: rtl/pixel_shade_pipe.sv
// Three-stage pixel shader: base colour, face shade, depth fog toward background.
// Latency: 3 cycles from input transfer to m_valid_out; 1 pixel per cycle.
// Backpressure: one global advance (!m_valid_out || m_ready_in) stalls every stage together.
module pixel_shade_pipe
  import pixel_shade_pkg::*;
#(
  parameter int COLOR_W   = 4,
  parameter int T_W       = 16,
  parameter int FOG_SHIFT = 6,
  parameter int H_ACTIVE  = 1024,
  parameter int V_ACTIVE  = 768
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 s_valid_in,
  output logic                 s_ready_out,
  input  logic [10:0]          x_in,
  input  logic [9:0]           y_in,
  input  logic                 hit_in,
  input  logic [1:0]           color_in,
  input  logic [2:0]           dir_in,
  input  logic [T_W-1:0]       t_in,
  input  logic                 fog_en_in,
  input  logic [3*COLOR_W-1:0] bg_rgb_in,
  output logic                 m_valid_out,
  input  logic                 m_ready_in,
  output logic [10:0]          x_out,
  output logic [9:0]           y_out,
  output logic [COLOR_W-1:0]   r_out,
  output logic [COLOR_W-1:0]   g_out,
  output logic [COLOR_W-1:0]   b_out,
  output logic                 frame_done_out
);

  // Channel order inside a packed triple: [2]=r, [1]=g, [0]=b, matching bg_rgb_in.
  typedef logic [2:0][COLOR_W-1:0] rgb_t;

  localparam logic [COLOR_W-1:0] CMAX   = '1;
  localparam logic [COLOR_W-1:0] CZERO  = '0;
  localparam logic [10:0]        X_LAST = 11'(H_ACTIVE - 1);
  localparam logic [9:0]         Y_LAST = 10'(V_ACTIVE - 1);

  logic                          adv;
  logic                          s1_vld, s2_vld;
  rec_t                          in_rec, s1_rec, s2_rec;
  rgb_t                          bg_rgb, base_rgb, s1_rgb, shade_rgb, s2_rgb, lerp_rgb, fog_rgb;
  logic [2:0]                    s1_dir;
  logic [2:0][COLOR_W+3:0]       prod;
  logic                          unused_prod;
  logic [REC_T_W-1:0]            t_shift;
  logic [COLOR_W-1:0]            fog_f;

  // A bubble at the output lets the whole pipe move even while downstream is stalled.
  assign adv         = !m_valid_out || m_ready_in;
  assign s_ready_out = adv;
  assign bg_rgb      = bg_rgb_in;

  // Stage 1: pack the sideband and pick the base colour (background on a miss).
  always_comb begin
    in_rec        = '0;
    in_rec.x      = x_in;
    in_rec.y      = y_in;
    in_rec.hit    = hit_in;
    in_rec.fog_en = fog_en_in;
    in_rec.t      = REC_T_W'(t_in);
    base_rgb      = bg_rgb;
    if (hit_in) begin
      case (color_e'(color_in))
        COL_RED:     base_rgb = {CMAX,  CZERO, CZERO};
        COL_BLUE:    base_rgb = {CZERO, CZERO, CMAX};
        COL_WHITE:   base_rgb = {CMAX,  CMAX,  CMAX};
        COL_MAGENTA: base_rgb = {CMAX,  CZERO, CMAX};
        default:     base_rgb = bg_rgb;
      endcase
    end
  end

  // Stage 2: scale each channel by the face weight in eighths; misses pass through.
  always_comb begin
    prod      = '0;
    shade_rgb = s1_rgb;
    for (int i = 0; i < 3; i++) begin
      prod[i] = (COLOR_W+4)'(s1_rgb[i]) * (COLOR_W+4)'(shade_weight(s1_dir));
      if (s1_rec.hit) shade_rgb[i] = prod[i][COLOR_W+2:3];
    end
  end
  assign unused_prod = ^prod;

  // Stage 3: fog factor saturates at full-scale so far hits keep a sliver of colour.
  always_comb begin
    t_shift = s2_rec.t >> FOG_SHIFT;
    fog_f   = (t_shift > REC_T_W'(CMAX)) ? CMAX : t_shift[COLOR_W-1:0];
    fog_rgb = (s2_rec.hit && s2_rec.fog_en) ? lerp_rgb : s2_rgb;
  end

  for (genvar i = 0; i < 3; i++) begin : g_lerp
    rgb_lerp #(.COLOR_W(COLOR_W)) u_lerp (
      .c   (s2_rgb[i]),
      .bg  (bg_rgb[i]),
      .f   (fog_f),
      .mix (lerp_rgb[i])
    );
  end

  // Stage 1 register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_vld <= 1'b0;
      s1_rec <= '0;
      s1_rgb <= '0;
      s1_dir <= '0;
    end else if (adv) begin
      s1_vld <= s_valid_in;
      s1_rec <= in_rec;
      s1_rgb <= base_rgb;
      s1_dir <= dir_in;
    end
  end

  // Stage 2 register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s2_vld <= 1'b0;
      s2_rec <= '0;
      s2_rgb <= '0;
    end else if (adv) begin
      s2_vld <= s1_vld;
      s2_rec <= s1_rec;
      s2_rgb <= shade_rgb;
    end
  end

  // Output register; holds stable whenever downstream stalls a valid pixel.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      m_valid_out <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
    end else if (adv) begin
      m_valid_out <= s2_vld;
      x_out       <= s2_rec.x;
      y_out       <= s2_rec.y;
      r_out       <= fog_rgb[2];
      g_out       <= fog_rgb[1];
      b_out       <= fog_rgb[0];
    end
  end

  // Frame-done pulse follows the accepted last pixel; updated every cycle so it stays one cycle wide.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      frame_done_out <= 1'b0;
    end else begin
      frame_done_out <= m_valid_out && m_ready_in && (x_out == X_LAST) && (y_out == Y_LAST);
    end
  end

endmodule

// File: tb/tb_pixel_shade_pipe.sv
`timescale 1ns/1ps
module tb_pixel_shade_pipe;

  localparam int CW = 4;
  localparam int TW = 16;
  localparam int FS = 6;
  localparam int HA = 4;
  localparam int VA = 2;
  localparam int M  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [10:0]   x = '0;
  logic [9:0]    y = '0;
  logic          hit = 1'b0;
  logic [1:0]    color = '0;
  logic [2:0]    dir = '0;
  logic [TW-1:0] t = '0;
  logic          fog_en = 1'b0;
  logic [CW-1:0] bg_r = '0, bg_g = '0, bg_b = '0;
  logic [3*CW-1:0] bg_rgb;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [10:0]   x_o;
  logic [9:0]    y_o;
  logic [CW-1:0] r_o, g_o, b_o;
  logic          fd;

  assign bg_rgb = {bg_r, bg_g, bg_b};

  always #5 clk = ~clk;

  pixel_shade_pipe #(
    .COLOR_W(CW), .T_W(TW), .FOG_SHIFT(FS), .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .clk_in(clk), .rst_in(rst_n),
    .s_valid_in(s_valid), .s_ready_out(s_ready),
    .x_in(x), .y_in(y), .hit_in(hit), .color_in(color), .dir_in(dir), .t_in(t),
    .fog_en_in(fog_en), .bg_rgb_in(bg_rgb),
    .m_valid_out(m_valid), .m_ready_in(m_ready),
    .x_out(x_o), .y_out(y_o), .r_out(r_o), .g_out(g_o), .b_out(b_o),
    .frame_done_out(fd)
  );

  int total = 0;
  int passed = 0;
  int fd_count = 0;
  bit rand_on = 0;

  typedef struct {int x; int y; int r; int g; int b;} exp_t;
  exp_t sbq[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: colour table, eighths shading, then a linear fog mix in plain integer maths.
  function automatic void model(input int mhit, mcol, mdir, mt, mfog,
                                output int r, output int g, output int b);
    int c[3];
    int bg[3];
    int k;
    int f;
    bg[0] = int'(bg_r); bg[1] = int'(bg_g); bg[2] = int'(bg_b);
    case (mcol)
      0:       begin c[0] = M; c[1] = 0; c[2] = 0; end
      1:       begin c[0] = 0; c[1] = 0; c[2] = M; end
      2:       begin c[0] = M; c[1] = M; c[2] = M; end
      default: begin c[0] = M; c[1] = 0; c[2] = M; end
    endcase
    case (mdir)
      0, 6, 7: k = 8;
      1:       k = 7;
      2, 3:    k = 6;
      4:       k = 5;
      default: k = 4;
    endcase
    if (mhit == 0) begin
      for (int i = 0; i < 3; i++) c[i] = bg[i];
    end else begin
      for (int i = 0; i < 3; i++) c[i] = (c[i] * k) / 8;
      if (mfog != 0) begin
        f = mt / (1 << FS);
        if (f > M) f = M;
        for (int i = 0; i < 3; i++) c[i] = (c[i] * (M + 1 - f) + bg[i] * f) / (M + 1);
      end
    end
    r = c[0]; g = c[1]; b = c[2];
  endfunction

  // Starts and ends on a posedge; the expectation is queued at the accepting edge.
  task automatic send(input int sx, sy, shit, scol, sdir, st, sfog, er, eg, eb);
    bit rdy;
    bit done;
    exp_t e;
    done = 0;
    #1;
    s_valid = 1'b1;
    x = 11'(sx); y = 10'(sy); hit = 1'(shit); color = 2'(scol);
    dir = 3'(sdir); t = TW'(st); fog_en = 1'(sfog);
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      if (rdy) begin
        e.x = sx; e.y = sy; e.r = er; e.g = eg; e.b = eb;
        sbq.push_back(e);
        done = 1;
      end
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic send_m(input int sx, sy, shit, scol, sdir, st, sfog);
    int r, g, b;
    model(shit, scol, sdir, st, sfog, r, g, b);
    send(sx, sy, shit, scol, sdir, st, sfog, r, g, b);
  endtask

  task automatic gap(input int n);
    #1 s_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic drain();
    #1 s_valid = 1'b0;
    for (int n = 0; n < 100 && sbq.size() != 0; n++) @(posedge clk);
    check("drain_empty", sbq.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  // Lone pixel just accepted: valid must appear in the third cycle after and last one cycle.
  task automatic lat_check(input string nm);
    #1 s_valid = 1'b0;
    @(negedge clk); check($sformatf("%s_lat_c1", nm), m_valid, 0);
    @(negedge clk); check($sformatf("%s_lat_c2", nm), m_valid, 0);
    @(negedge clk); check($sformatf("%s_lat_c3", nm), m_valid, 1);
    @(negedge clk); check($sformatf("%s_lat_c4", nm), m_valid, 0);
    @(posedge clk);
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stall/frame rules.
  bit     stall_prev = 0;
  bit     last_prev = 0;
  longint held = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 0;
      last_prev  = 0;
    end else begin
      check("frame_done", fd, last_prev);
      if (fd) fd_count++;
      if (stall_prev) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", {x_o, y_o, r_o, g_o, b_o}, held);
      end
      if (m_valid && !m_ready) check("s_ready_stall", s_ready, 0);
      if (m_valid && m_ready) begin
        total++;
        if (sbq.size() == 0) begin
          $display("FAIL unexpected_pixel: got (%0d,%0d) rgb %0d,%0d,%0d, expected none",
                   x_o, y_o, r_o, g_o, b_o);
        end else begin
          e = sbq.pop_front();
          if (int'(x_o) == e.x && int'(y_o) == e.y && int'(r_o) == e.r &&
              int'(g_o) == e.g && int'(b_o) == e.b) passed++;
          else $display("FAIL pixel: got (%0d,%0d) rgb %0d,%0d,%0d, expected (%0d,%0d) rgb %0d,%0d,%0d",
                        x_o, y_o, r_o, g_o, b_o, e.x, e.y, e.r, e.g, e.b);
        end
      end
      stall_prev = m_valid && !m_ready;
      held       = {x_o, y_o, r_o, g_o, b_o};
      last_prev  = m_valid && m_ready && (int'(x_o) == HA - 1) && (int'(y_o) == VA - 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int fd0;
    int st;
    #1 rst_n = 1'b0;
    #2;
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_frame_done", fd, 0);
    check("rst_data", {x_o, y_o, r_o, g_o, b_o}, 0);
    #20 rst_n = 1'b1;
    @(posedge clk);

    // Plain red hit and its latency.
    send(100, 50, 1, 0, 0, 0, 0, 15, 0, 0);
    lat_check("t1");

    // Face shading, including the full-brightness unused face codes.
    send(1, 1, 1, 0, 5, 0, 0, 7, 0, 0);
    send(2, 1, 1, 2, 2, 0, 0, 11, 11, 11);
    send(3, 2, 1, 1, 7, 0, 0, 0, 0, 15);
    send(4, 2, 1, 3, 3, 0, 0, 11, 0, 11);
    send(5, 2, 1, 0, 6, 0, 0, 15, 0, 0);
    drain();
    bg_r = 4'd1; bg_g = 4'd2; bg_b = 4'd3;
    send(10, 2, 0, 1, 5, 0, 0, 1, 2, 3);
    send(11, 2, 0, 0, 5, 512, 1, 1, 2, 3);
    drain();

    // Fog, including the saturated factor.
    bg_r = 4'd0; bg_g = 4'd0; bg_b = 4'd0;
    send(20, 3, 1, 0, 0, 512, 1, 7, 0, 0);
    send(21, 3, 1, 0, 0, 0, 1, 15, 0, 0);
    send(22, 3, 1, 0, 0, 65535, 1, 0, 0, 0);
    drain();
    bg_r = 4'd0; bg_g = 4'd15; bg_b = 4'd0;
    send(23, 3, 1, 0, 0, 512, 1, 7, 7, 0);
    send(24, 3, 1, 0, 5, 512, 1, 3, 7, 0);
    drain();

    // Backpressure: six back-to-back pixels with the output stalled mid-stream.
    fork
      begin
        for (int i = 0; i < 6; i++) send_m(i, 7, 1, i % 4, i, 64 * i, i % 2);
      end
      begin
        repeat (4) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    #1 s_valid = 1'b0; m_ready = 1'b1;
    @(posedge clk);
    drain();

    // Frame done: full 4x2 frame, last pixel held under stall before release.
    fd0 = fd_count;
    for (int i = 0; i < 8; i++) send_m(i % 4, i / 4, 1, 2, i % 6, 100 * i, 1);
    #1 s_valid = 1'b0; m_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk);
    drain();
    check("frame_done_pulses", fd_count - fd0, 1);

    // Reset with three pixels in flight.
    for (int i = 0; i < 3; i++) send_m(30 + i, 4, 1, 1, 1, 0, 0);
    #2 rst_n = 1'b0; s_valid = 1'b0;
    #1;
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_data", {x_o, y_o, r_o, g_o, b_o}, 0);
    check("mid_rst_frame_done", fd, 0);
    check("mid_rst_s_ready", s_ready, 1);
    sbq.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", m_valid, 0);
    end
    @(posedge clk);
    send_m(40, 5, 1, 3, 4, 300, 1);
    lat_check("t6");
    drain();

    // Randomised traffic with random downstream readiness.
    bg_r = 4'($urandom_range(0, M)); bg_g = 4'($urandom_range(0, M)); bg_b = 4'($urandom_range(0, M));
    rand_on = 1;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 4) == 0) gap(1);
          st = ($urandom_range(0, 9) == 0) ? 65535 : int'($urandom_range(0, 1100));
          send_m(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)), st, int'($urandom_range(0, 1)));
        end
        rand_on = 0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1 m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    #1 s_valid = 1'b0; m_ready = 1'b1;
    @(posedge clk);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
